nes_joypad_mux: RTL and testbench

//  Parametrised NES controller-port engine replacing the inline $4016/$4017 shift logic in the NES top.

---
 rtl/nes_joypad_mux_if.sv | 35 +++
 rtl/nes_joypad_mux.sv | 129 ++++++++++++
 tb/tb_nes_joypad_mux.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/nes_joypad_mux_if.sv
// nes_joypad_mux_if
//   Bundles the joypad engine's bus-side signals. The master side holds the
//   NES core's strobe/read pulses and the controller decoders' button vectors.
//   The slave side is the nes_joypad_mux engine.
//
//   strobe        $4016 bit0 latch, active high
//   joypad_clock  per-port CPU read pulses (port0 = $4016, port1 = $4017)
//   fourscore_en  multitap mode request, sampled on each load
//   btn           per pad {R,L,D,U,St,Se,B,A}, pad p in [8p+7:8p]
//   loader_btn    UART loader override, same layout as btn
//   turbo_en      per pad {B,A} turbo enables, pad p in [2p+1:2p]
//   joy_data      current serial bit per port
//   shift_done    per port: every data bit has been consumed since the last load
interface nes_joypad_mux_if #(
  parameter int NUM_PADS = 2
);
  logic                    strobe;
  logic [1:0]              joypad_clock;
  logic                    fourscore_en;
  logic [8*NUM_PADS-1:0]   btn;
  logic [8*NUM_PADS-1:0]   loader_btn;
  logic [2*NUM_PADS-1:0]   turbo_en;
  logic [1:0]              joy_data;
  logic [1:0]              shift_done;

  modport master (
    output strobe, joypad_clock, fourscore_en, btn, loader_btn, turbo_en,
    input  joy_data, shift_done
  );

  modport slave (
    input  strobe, joypad_clock, fourscore_en, btn, loader_btn, turbo_en,
    output joy_data, shift_done
  );
endinterface

// File: rtl/nes_joypad_mux.sv
// nes_joypad_mux
//   NES controller-port engine. It merges up to four pads (decoded buttons ORed
//   with the UART loader overrides) and adds free-running turbo on A/B. It then
//   serialises the result to the CPU on two ports. There are two read formats:
//   standard 8-bit reads, and Four Score 24-bit reads that end in a signature.
//
//   clk     system clock
//   resetn  asynchronous active-low reset
//   bus     nes_joypad_mux_if slave modport (strobe, read pulses, pad inputs,
//           serial data and shift_done outputs)
module nes_joypad_mux #(
  parameter int         NUM_PADS    = 2,
  parameter int         FREQ        = 21_477_272,
  parameter int         TURBO_HZ    = 10,
  parameter int         SYNC_STAGES = 2,
  parameter logic       FILL_BIT    = 1'b1,
  parameter logic [7:0] SIG_P0      = 8'h08,
  parameter logic [7:0] SIG_P1      = 8'h04
) (
  input logic             clk,
  input logic             resetn,
  nes_joypad_mux_if.slave bus
);

  localparam int             HALF    = FREQ / (2 * TURBO_HZ);
  localparam int             TCW     = $clog2(HALF + 1);
  localparam logic [TCW-1:0] HALF_M1 = TCW'(HALF - 1);
  localparam logic [4:0]     LEN_STD = 5'd8;
  localparam logic [4:0]     LEN_FS  = 5'd24;

  logic [SYNC_STAGES-1:0][8*NUM_PADS-1:0] btn_sync_q;
  logic [SYNC_STAGES-1:0][2*NUM_PADS-1:0] turbo_sync_q;
  logic [8*NUM_PADS-1:0]                  btn_s;
  logic [2*NUM_PADS-1:0]                  turbo_s;

  logic [TCW-1:0]     turbo_cnt_q;
  logic               phase_q;
  logic [3:0][7:0]    eff;

  logic [1:0][23:0]   sreg_q;
  logic [1:0][4:0]    cnt_q;
  logic [1:0]         last_clk_q;
  logic               mode_q;
  logic               load_fs;
  logic [4:0]         len;

  assign btn_s   = btn_sync_q[SYNC_STAGES-1];
  assign turbo_s = turbo_sync_q[SYNC_STAGES-1];
  assign load_fs = bus.fourscore_en & (NUM_PADS == 4);
  assign len     = mode_q ? LEN_FS : LEN_STD;

  // Synchroniser chains for the asynchronous pad and turbo inputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btn_sync_q   <= '0;
      turbo_sync_q <= '0;
    end else begin
      btn_sync_q[0]   <= bus.btn;
      turbo_sync_q[0] <= bus.turbo_en;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        btn_sync_q[i]   <= btn_sync_q[i-1];
        turbo_sync_q[i] <= turbo_sync_q[i-1];
      end
    end
  end

  // Free-running turbo phase, shared by all pads.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      turbo_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (turbo_cnt_q == HALF_M1) begin
      turbo_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      turbo_cnt_q <= turbo_cnt_q + TCW'(1);
    end
  end

  // Effective pad state. Pads beyond NUM_PADS stay zero, so the Four Score
  // packing below elaborates for a two-pad build too.
  always_comb begin
    eff = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      eff[p]    = btn_s[8*p +: 8] | bus.loader_btn[8*p +: 8];
      eff[p][0] = eff[p][0] | (turbo_s[2*p]   & phase_q);
      eff[p][1] = eff[p][1] | (turbo_s[2*p+1] & phase_q);
    end
  end

  // Load and shift. A strobe beats a coincident falling edge. The counter
  // saturates at the frame length, so late reads only return FILL_BIT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sreg_q     <= '0;
      cnt_q      <= '0;
      last_clk_q <= '0;
      mode_q     <= 1'b0;
    end else begin
      last_clk_q <= bus.joypad_clock;
      if (bus.strobe) begin
        mode_q <= load_fs;
        cnt_q  <= '0;
        if (load_fs) begin
          sreg_q[0] <= {SIG_P0, eff[2], eff[0]};
          sreg_q[1] <= {SIG_P1, eff[3], eff[1]};
        end else begin
          sreg_q[0] <= {{16{FILL_BIT}}, eff[0]};
          sreg_q[1] <= {{16{FILL_BIT}}, eff[1]};
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (last_clk_q[p] && !bus.joypad_clock[p]) begin
            sreg_q[p] <= {FILL_BIT, sreg_q[p][23:1]};
            if (cnt_q[p] != len) begin
              cnt_q[p] <= cnt_q[p] + 5'd1;
            end
          end
        end
      end
    end
  end

  assign bus.joy_data[0]   = sreg_q[0][0];
  assign bus.joy_data[1]   = sreg_q[1][0];
  assign bus.shift_done[0] = (cnt_q[0] == len);
  assign bus.shift_done[1] = (cnt_q[1] == len);

endmodule

// File: tb/tb_nes_joypad_mux.sv
// tb_nes_joypad_mux
//   Directed bench for nes_joypad_mux. It uses a four-pad instance with a short
//   turbo period (half-period = 4 clks) and a two-pad instance. The two-pad
//   instance must ignore fourscore_en.
module tb_nes_joypad_mux;

  logic clk;
  logic resetn;
  int   errors = 0;
  int   checks = 0;

  nes_joypad_mux_if #(.NUM_PADS(4)) if4 ();
  nes_joypad_mux_if #(.NUM_PADS(2)) if2 ();

  nes_joypad_mux #(
    .NUM_PADS(4), .FREQ(80), .TURBO_HZ(10), .SYNC_STAGES(2),
    .FILL_BIT(1'b1), .SIG_P0(8'h08), .SIG_P1(8'h04)
  ) dut4 (
    .clk(clk), .resetn(resetn), .bus(if4.slave)
  );

  nes_joypad_mux #(
    .NUM_PADS(2), .FREQ(80), .TURBO_HZ(10), .SYNC_STAGES(2),
    .FILL_BIT(1'b1), .SIG_P0(8'h08), .SIG_P1(8'h04)
  ) dut2 (
    .clk(clk), .resetn(resetn), .bus(if2.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives every bus input on both instances to its idle value.
  task automatic clear_inputs();
    if4.strobe = 1'b0; if4.joypad_clock = 2'b00; if4.fourscore_en = 1'b0;
    if4.btn = '0; if4.loader_btn = '0; if4.turbo_en = '0;
    if2.strobe = 1'b0; if2.joypad_clock = 2'b00; if2.fourscore_en = 1'b0;
    if2.btn = '0; if2.loader_btn = '0; if2.turbo_en = '0;
  endtask

  // Holds strobe long enough for the button synchronisers to settle.
  // The task returns on a negedge just after the final load edge.
  task automatic do_strobe();
    @(negedge clk);
    if4.strobe = 1'b1; if2.strobe = 1'b1;
    repeat (4) @(negedge clk);
    if4.strobe = 1'b0; if2.strobe = 1'b0;
  endtask

  // One CPU read pulse on a port, applied to both instances. The task
  // returns on a negedge where the shifted data is already visible.
  task automatic pulse(input int port);
    @(negedge clk);
    if4.joypad_clock[port] = 1'b1; if2.joypad_clock[port] = 1'b1;
    @(negedge clk);
    if4.joypad_clock[port] = 1'b0; if2.joypad_clock[port] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_inputs();
    #3;
    checks++; if (if4.joy_data !== 2'b00) begin errors++; $display("[TB] FAIL reset_joy4 got=%b exp=00", if4.joy_data); end
    checks++; if (if4.shift_done !== 2'b00) begin errors++; $display("[TB] FAIL reset_done4 got=%b exp=00", if4.shift_done); end
    checks++; if (if2.joy_data !== 2'b00) begin errors++; $display("[TB] FAIL reset_joy2 got=%b exp=00", if2.joy_data); end
    checks++; if (if2.shift_done !== 2'b00) begin errors++; $display("[TB] FAIL reset_done2 got=%b exp=00", if2.shift_done); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_standard();
    logic [7:0] pad;
    logic       exp;
    pad = 8'h09;
    clear_inputs();
    if4.btn[7:0] = pad;
    if2.btn[7:0] = pad;
    do_strobe();
    for (int i = 0; i < 10; i++) begin
      exp = (i < 8) ? pad[i] : 1'b1;
      checks++; if (if4.joy_data[0] !== exp) begin errors++; $display("[TB] FAIL std_read%0d got=%b exp=%b", i + 1, if4.joy_data[0], exp); end
      checks++; if (if4.shift_done[0] !== (i >= 8)) begin errors++; $display("[TB] FAIL std_done_after%0d got=%b exp=%b", i, if4.shift_done[0], (i >= 8)); end
      pulse(0);
    end
  endtask

  task automatic test_latency();
    clear_inputs();
    @(negedge clk);
    if4.strobe = 1'b1;
    repeat (4) @(negedge clk);
    if4.btn[7:0] = 8'h01;
    for (int n = 1; n <= 3; n++) begin
      @(posedge clk);
      #1;
      checks++; if (if4.joy_data[0] !== (n == 3)) begin errors++; $display("[TB] FAIL latency_clk%0d got=%b exp=%b", n, if4.joy_data[0], (n == 3)); end
    end
    @(negedge clk);
    if4.strobe = 1'b0;
  endtask

  task automatic test_fourscore();
    logic [23:0] s0;
    logic [23:0] s1;
    logic [7:0]  p2;
    logic        exp;
    s0 = {8'h08, 8'h80, 8'h01};
    s1 = {8'h04, 8'h40, 8'h02};
    p2 = 8'h01;
    clear_inputs();
    if4.btn = {8'h40, 8'h80, 8'h02, 8'h01};
    if4.fourscore_en = 1'b1;
    if2.btn = {8'h02, 8'h01};
    if2.fourscore_en = 1'b1;
    do_strobe();
    if4.fourscore_en = 1'b0;
    if2.fourscore_en = 1'b0;
    for (int i = 0; i < 25; i++) begin
      exp = (i < 24) ? s0[i] : 1'b1;
      checks++; if (if4.joy_data[0] !== exp) begin errors++; $display("[TB] FAIL fs_p0_read%0d got=%b exp=%b", i + 1, if4.joy_data[0], exp); end
      exp = (i < 8) ? p2[i] : 1'b1;
      checks++; if (if2.joy_data[0] !== exp) begin errors++; $display("[TB] FAIL fs_2pad_read%0d got=%b exp=%b", i + 1, if2.joy_data[0], exp); end
      if (i == 8 || i == 23 || i == 24) begin
        checks++; if (if4.shift_done[0] !== (i >= 24)) begin errors++; $display("[TB] FAIL fs_done_after%0d got=%b exp=%b", i, if4.shift_done[0], (i >= 24)); end
        checks++; if (if2.shift_done[0] !== 1'b1) begin errors++; $display("[TB] FAIL fs_2pad_done_after%0d got=%b exp=1", i, if2.shift_done[0]); end
      end
      pulse(0);
    end
    for (int i = 0; i < 25; i++) begin
      exp = (i < 24) ? s1[i] : 1'b1;
      checks++; if (if4.joy_data[1] !== exp) begin errors++; $display("[TB] FAIL fs_p1_read%0d got=%b exp=%b", i + 1, if4.joy_data[1], exp); end
      pulse(1);
    end
    checks++; if (if4.shift_done !== 2'b11) begin errors++; $display("[TB] FAIL fs_done_both got=%b exp=11", if4.shift_done); end
  endtask

  task automatic test_collision();
    clear_inputs();
    if4.btn[7:0] = 8'h01;
    do_strobe();
    pulse(0);
    pulse(0);
    checks++; if (if4.joy_data[0] !== 1'b0) begin errors++; $display("[TB] FAIL coll_pre got=%b exp=0", if4.joy_data[0]); end
    @(negedge clk);
    if4.joypad_clock[0] = 1'b1;
    @(negedge clk);
    if4.joypad_clock[0] = 1'b0;
    if4.strobe = 1'b1;
    @(negedge clk);
    if4.strobe = 1'b0;
    checks++; if (if4.joy_data[0] !== 1'b1) begin errors++; $display("[TB] FAIL coll_load got=%b exp=1", if4.joy_data[0]); end
    @(negedge clk);
    checks++; if (if4.joy_data[0] !== 1'b1) begin errors++; $display("[TB] FAIL coll_noshift got=%b exp=1", if4.joy_data[0]); end
    repeat (7) pulse(0);
    checks++; if (if4.shift_done[0] !== 1'b0) begin errors++; $display("[TB] FAIL coll_done7 got=%b exp=0", if4.shift_done[0]); end
    pulse(0);
    checks++; if (if4.shift_done[0] !== 1'b1) begin errors++; $display("[TB] FAIL coll_done8 got=%b exp=1", if4.shift_done[0]); end
  endtask

  task automatic test_override();
    clear_inputs();
    if4.loader_btn[15:8] = 8'h10;
    do_strobe();
    for (int i = 0; i < 8; i++) begin
      checks++; if (if4.joy_data[1] !== (i == 4)) begin errors++; $display("[TB] FAIL ovr_read%0d got=%b exp=%b", i + 1, if4.joy_data[1], (i == 4)); end
      pulse(1);
    end
  endtask

  task automatic test_turbo();
    logic exp;
    @(negedge clk);
    resetn = 1'b0;
    clear_inputs();
    if4.turbo_en[2] = 1'b1;
    if4.strobe = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk);
      #1;
      exp = (n >= 3) && ((((n - 1) / 4) % 2) == 1);
      checks++; if (if4.joy_data[1] !== exp) begin errors++; $display("[TB] FAIL turbo_clk%0d got=%b exp=%b", n, if4.joy_data[1], exp); end
    end
    checks++; if (if4.joy_data[0] !== 1'b0) begin errors++; $display("[TB] FAIL turbo_pad0 got=%b exp=0", if4.joy_data[0]); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_midread();
    logic [7:0] pad;
    clear_inputs();
    if4.btn[15:0] = {8'h55, 8'hA8};
    do_strobe();
    repeat (8) pulse(1);
    repeat (3) pulse(0);
    checks++; if (if4.joy_data[0] !== 1'b1) begin errors++; $display("[TB] FAIL mid_bit3 got=%b exp=1", if4.joy_data[0]); end
    checks++; if (if4.shift_done[1] !== 1'b1) begin errors++; $display("[TB] FAIL mid_done1 got=%b exp=1", if4.shift_done[1]); end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (if4.joy_data !== 2'b00) begin errors++; $display("[TB] FAIL mid_rst_joy got=%b exp=00", if4.joy_data); end
    checks++; if (if4.shift_done !== 2'b00) begin errors++; $display("[TB] FAIL mid_rst_done got=%b exp=00", if4.shift_done); end
    @(negedge clk);
    resetn = 1'b1;
    pad = 8'h3C;
    if4.btn[7:0] = pad;
    do_strobe();
    for (int i = 0; i < 8; i++) begin
      checks++; if (if4.joy_data[0] !== pad[i]) begin errors++; $display("[TB] FAIL mid_after_read%0d got=%b exp=%b", i + 1, if4.joy_data[0], pad[i]); end
      pulse(0);
    end
    checks++; if (if4.shift_done[0] !== 1'b1) begin errors++; $display("[TB] FAIL mid_after_done got=%b exp=1", if4.shift_done[0]); end
  endtask

  initial begin
    test_reset();
    test_standard();
    test_latency();
    test_fourscore();
    test_collision();
    test_override();
    test_turbo();
    test_reset_midread();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
